// File: rtl/otsu_binarize.sv
// otsu_binarize: RGB888 pixel pairs -> 8-bit luma -> per-frame threshold, 2-stage pipe.
// Define OTSU_HIST_EN to add a 256-bin luma histogram with a registered read port.
module otsu_binarize #(
    parameter int unsigned WIDTH   = 768,
    parameter int unsigned HEIGHT  = 512,
    parameter int unsigned DEF_THR = 128
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        hsync_in,
    input  logic [7:0]  DATA_R0,
    input  logic [7:0]  DATA_G0,
    input  logic [7:0]  DATA_B0,
    input  logic [7:0]  DATA_R1,
    input  logic [7:0]  DATA_G1,
    input  logic [7:0]  DATA_B1,
    input  logic [7:0]  thr_in,
    input  logic        thr_load,
    output logic        hsync,
    output logic [7:0]  DATA_WRITE_R0,
    output logic [7:0]  DATA_WRITE_G0,
    output logic [7:0]  DATA_WRITE_B0,
    output logic [7:0]  DATA_WRITE_R1,
    output logic [7:0]  DATA_WRITE_G1,
    output logic [7:0]  DATA_WRITE_B1,
    output logic        frame_done,
    input  logic [7:0]  hist_addr,
    output logic [18:0] hist_data
);
    localparam int unsigned NPAIR = WIDTH * HEIGHT / 2;
    localparam int unsigned CW = $clog2(NPAIR + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NPAIR - 1);
    localparam logic [7:0] THR_RST = 8'(DEF_THR);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       thr_pend_q, thr_pend_d;
    logic [7:0]       thr_frame_q, thr_frame_d;
    logic [2:0][15:0] prod0_q, prod0_d;
    logic [2:0][15:0] prod1_q, prod1_d;
    logic [7:0]       thr1_q, thr1_d;
    logic             v1_q, v1_d;
    logic             last1_q, last1_d;
    logic             first1_q, first1_d;
    logic             hsync_q, hsync_d;
    logic             done_q, done_d;
    logic [7:0]       pix0_q, pix0_d;
    logic [7:0]       pix1_q, pix1_d;

    logic       first;
    logic [7:0] thr_use;
    logic [7:0] y0, y1;

    always_comb begin
        cnt_d       = cnt_q;
        thr_pend_d  = thr_pend_q;
        thr_frame_d = thr_frame_q;
        prod0_d     = prod0_q;
        prod1_d     = prod1_q;
        thr1_d      = thr1_q;
        last1_d     = last1_q;
        first1_d    = first1_q;
        pix0_d      = pix0_q;
        pix1_d      = pix1_q;

        first   = hsync_in && (cnt_q == '0);
        thr_use = thr_frame_q;
        if (first) begin
            thr_use = thr_load ? thr_in : thr_pend_q;
        end
        if (thr_load) begin
            thr_pend_d = thr_in;
        end
        if (first) begin
            thr_frame_d = thr_use;
        end

        // Threshold and frame markers ride along with each pair.
        v1_d = hsync_in;
        if (hsync_in) begin
            cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            prod0_d[0] = 16'(DATA_R0) * 16'd77;
            prod0_d[1] = 16'(DATA_G0) * 16'd150;
            prod0_d[2] = 16'(DATA_B0) * 16'd29;
            prod1_d[0] = 16'(DATA_R1) * 16'd77;
            prod1_d[1] = 16'(DATA_G1) * 16'd150;
            prod1_d[2] = 16'(DATA_B1) * 16'd29;
            thr1_d     = thr_use;
            last1_d    = (cnt_q == CNT_MAX);
            first1_d   = first;
        end

        y0 = 8'((prod0_q[0] + prod0_q[1] + prod0_q[2]) >> 8);
        y1 = 8'((prod1_q[0] + prod1_q[1] + prod1_q[2]) >> 8);

        hsync_d = v1_q;
        done_d  = v1_q && last1_q;
        if (v1_q) begin
            pix0_d = (y0 >= thr1_q) ? 8'hFF : 8'h00;
            pix1_d = (y1 >= thr1_q) ? 8'hFF : 8'h00;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cnt_q       <= '0;
            thr_pend_q  <= THR_RST;
            thr_frame_q <= THR_RST;
            prod0_q     <= '0;
            prod1_q     <= '0;
            thr1_q      <= '0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            first1_q    <= 1'b0;
            hsync_q     <= 1'b0;
            done_q      <= 1'b0;
            pix0_q      <= '0;
            pix1_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            thr_pend_q  <= thr_pend_d;
            thr_frame_q <= thr_frame_d;
            prod0_q     <= prod0_d;
            prod1_q     <= prod1_d;
            thr1_q      <= thr1_d;
            v1_q        <= v1_d;
            last1_q     <= last1_d;
            first1_q    <= first1_d;
            hsync_q     <= hsync_d;
            done_q      <= done_d;
            pix0_q      <= pix0_d;
            pix1_q      <= pix1_d;
        end
    end

    assign hsync         = hsync_q;
    assign frame_done    = done_q;
    assign DATA_WRITE_R0 = pix0_q;
    assign DATA_WRITE_G0 = pix0_q;
    assign DATA_WRITE_B0 = pix0_q;
    assign DATA_WRITE_R1 = pix1_q;
    assign DATA_WRITE_G1 = pix1_q;
    assign DATA_WRITE_B1 = pix1_q;

`ifdef OTSU_HIST_EN
    logic [18:0] bin_q [256];
    logic [18:0] bin_d [256];
    logic [18:0] hist_q, hist_d;

    // Clearing and counting in one update lets a frame start from its first pair.
    always_comb begin
        bin_d  = bin_q;
        hist_d = bin_q[hist_addr];
        if (v1_q) begin
            if (first1_q) begin
                for (int i = 0; i < 256; i++) begin
                    bin_d[i] = '0;
                end
            end
            bin_d[y0] = bin_d[y0] + 19'd1;
            bin_d[y1] = bin_d[y1] + 19'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int i = 0; i < 256; i++) begin
                bin_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            bin_q  <= bin_d;
            hist_q <= hist_d;
        end
    end

    assign hist_data = hist_q;
`else
    logic unused_hist;
    assign unused_hist = ^{hist_addr, first1_q};
    assign hist_data   = '0;
`endif
endmodule

// File: tb/tb_otsu_binarize.sv
// tb_otsu_binarize: directed pairs against a frame-level model of otsu_binarize.
// Small frame geometry keeps full-frame runs short.
module tb_otsu_binarize;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int NP = W * H / 2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        hsync_in = 1'b0;
    logic [7:0]  DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
    logic [7:0]  DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
    logic [7:0]  thr_in = '0;
    logic        thr_load = 1'b0;
    logic [7:0]  hist_addr = '0;
    logic        hsync;
    logic [7:0]  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0;
    logic [7:0]  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1;
    logic        frame_done;
    logic [18:0] hist_data;

    otsu_binarize #(.WIDTH(W), .HEIGHT(H), .DEF_THR(128)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .hsync_in(hsync_in),
        .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
        .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
        .thr_in(thr_in), .thr_load(thr_load), .hsync(hsync),
        .DATA_WRITE_R0(DATA_WRITE_R0), .DATA_WRITE_G0(DATA_WRITE_G0),
        .DATA_WRITE_B0(DATA_WRITE_B0), .DATA_WRITE_R1(DATA_WRITE_R1),
        .DATA_WRITE_G1(DATA_WRITE_G1), .DATA_WRITE_B1(DATA_WRITE_B1),
        .frame_done(frame_done), .hist_addr(hist_addr), .hist_data(hist_data)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        bit         fd;
    } exp_t;

    exp_t       exp_q [int];
    int         checks = 0;
    int         failures = 0;
    int         pidx = 0;
    int         pend = 128;
    int         frm = 128;
    int         rst_cyc = -1;
    bit         chk_en = 1'b0;
    logic [7:0] held0 = '0;
    logic [7:0] held1 = '0;
    int         hs_cnt = 0;
    int         fd_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic int lum(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    // Every cycle: either the scheduled pair or idle with held data.
    always @(negedge HCLK) begin
        exp_t e;
        bit   has;
        if (chk_en) begin
            if (cyc == rst_cyc) begin
                held0 = '0;
                held1 = '0;
            end
            has = exp_q.exists(cyc);
            e.fd = 1'b0;
            if (has) begin
                e = exp_q[cyc];
                exp_q.delete(cyc);
                held0 = e.d0;
                held1 = e.d1;
            end
            chk("hsync", 32'(hsync), 32'(has));
            chk("frame_done", 32'(frame_done), 32'(has && e.fd));
            chk("pix0", {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0},
                {3{held0}});
            chk("pix1", {DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1},
                {3{held1}});
            if (hsync === 1'b1) hs_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic pair(input int r0, input int g0, input int b0,
                        input int r1, input int g1, input int b1,
                        input bit ld = 1'b0, input int th = 0);
        exp_t e;
        hsync_in = 1'b1;
        DATA_R0 = 8'(r0); DATA_G0 = 8'(g0); DATA_B0 = 8'(b0);
        DATA_R1 = 8'(r1); DATA_G1 = 8'(g1); DATA_B1 = 8'(b1);
        thr_load = ld;
        thr_in = 8'(th);
        if (pidx == 0) frm = ld ? th : pend;
        if (ld) pend = th;
        e.d0 = (lum(r0, g0, b0) >= frm) ? 8'hFF : 8'h00;
        e.d1 = (lum(r1, g1, b1) >= frm) ? 8'hFF : 8'h00;
        e.fd = (pidx == NP - 1);
        exp_q[cyc + 2] = e;
        pidx = (pidx + 1) % NP;
        @(posedge HCLK);
        #1;
        hsync_in = 1'b0;
        thr_load = 1'b0;
    endtask

    task automatic gray2(input int a, input int b,
                         input bit ld = 1'b0, input int th = 0);
        pair(a, a, a, b, b, b, ld, th);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic load_only(input int th);
        thr_load = 1'b1;
        thr_in = 8'(th);
        pend = th;
        @(posedge HCLK);
        #1;
        thr_load = 1'b0;
    endtask

    task automatic rand_pair();
        pair($urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255),
             ($urandom_range(0, 9) == 0), $urandom_range(0, 255));
        idle($urandom_range(0, 2));
    endtask

    task automatic do_reset();
        rst_cyc = cyc + 1;
        if (exp_q.exists(cyc + 1)) exp_q.delete(cyc + 1);
        if (exp_q.exists(cyc + 2)) exp_q.delete(cyc + 2);
        pidx = 0;
        pend = 128;
        frm = 128;
        HRESETn = 1'b0;
        hsync_in = 1'b0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    initial begin
        int hs0, fd0;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hsync", 32'(hsync), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_pix", {DATA_WRITE_R0, DATA_WRITE_B1}, 0);
        chk("rst_hist", 32'(hist_data), 0);
        HRESETn = 1'b1;
        chk_en = 1'b1;

        // White/black pair, two-cycle latency
        pair(255, 255, 255, 0, 0, 0);
        idle(1);
        chk("t1_hsync", 32'(hsync), 1);
        chk("t1_pix0", {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0}, 24'hFFFFFF);
        chk("t1_pix1", {DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1}, 24'h000000);

        // Luma edge at 128
        gray2(128, 127);
        idle(1);
        chk("t2_y128", 32'(DATA_WRITE_R0), 32'hFF);
        chk("t2_y127", 32'(DATA_WRITE_R1), 32'h00);

        // Mid-frame load only takes effect next frame
        gray2(150, 150);
        load_only(200);
        gray2(150, 150);
        idle(1);
        chk("t3_mid_old_thr", 32'(DATA_WRITE_R0), 32'hFF);
        while (pidx != 0) gray2(150, 150);
        gray2(150, 150);
        idle(1);
        chk("t3_next_thr200", 32'(DATA_WRITE_R0), 32'h00);
        while (pidx != 0) gray2(150, 150);
        gray2(150, 150, 1'b1, 100);
        idle(1);
        chk("t3_first_load", 32'(DATA_WRITE_R0), 32'hFF);
        while (pidx != 0) gray2(150, 150);
        idle(3);

        // Full random frame with gaps
        hs0 = hs_cnt;
        fd0 = fd_cnt;
        repeat (NP) rand_pair();
        idle(3);
        chk("t4_pulses", 32'(hs_cnt - hs0), 32'(NP));
        chk("t4_done", 32'(fd_cnt - fd0), 1);

        // Mid-frame reset discards in-flight pair and pending threshold
        gray2(200, 10, 1'b1, 60);
        gray2(200, 200);
        load_only(50);
        gray2(200, 200);
        fd0 = fd_cnt;
        do_reset();
        chk("t5_hsync0", 32'(hsync), 0);
        chk("t5_pix0", {DATA_WRITE_R0, DATA_WRITE_R1}, 0);
        gray2(100, 100);
        idle(1);
        chk("t5_hsync1", 32'(hsync), 1);
        chk("t5_def_thr", 32'(DATA_WRITE_R0), 32'h00);
        chk("t5_no_done", 32'(fd_cnt - fd0), 0);
        while (pidx != 0) rand_pair();
        idle(3);

`ifdef OTSU_HIST_EN
        repeat (NP) gray2(90, 90);
        idle(3);
        hist_addr = 8'd90;
        idle(1);
        chk("t6_bin90", 32'(hist_data), 32'(W * H));
        hist_addr = 8'd89;
        idle(1);
        chk("t6_bin89", 32'(hist_data), 0);
        hist_addr = 8'd91;
        idle(1);
        chk("t6_bin91", 32'(hist_data), 0);
        gray2(30, 30);
        idle(3);
        hist_addr = 8'd90;
        idle(1);
        chk("t6_clean90", 32'(hist_data), 0);
        hist_addr = 8'd30;
        idle(1);
        chk("t6_bin30", 32'(hist_data), 2);
        while (pidx != 0) gray2(30, 30);
        idle(3);
`else
        hist_addr = 8'd90;
        idle(1);
        chk("t6_hist_tied", 32'(hist_data), 0);
`endif

        chk("drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
